// File: rtl/biquad_coeff_loader_pkg.sv
// Shared types and constants for the biquad coefficient loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package biquad_coeff_loader_pkg;

    // Width of one coefficient, matching the DSP B port.
    localparam int COEFF_BITS     = 18;

    // A biquad8 pair shares one coefficient bus: two B stages per load.
    localparam int DEFAULT_NCOEFF = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_HOLD   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/biquad_coeff_shadow.sv
// Shadow register file holding the coefficients of the next load sequence.
// Latency: write lands at the clock edge; read is combinational (0 cycles).
// Backpressure: none; writes are always accepted, out-of-range addresses are dropped.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset (clears all entries)
//   wr_en/wr_adr/wr_dat  synchronous write port
//   rd_adr/rd_dat        combinational read port (0 for out-of-range addresses)
module biquad_coeff_shadow
    import biquad_coeff_loader_pkg::*;
#(
    parameter int NCOEFF  = DEFAULT_NCOEFF,
    parameter int CBITS   = COEFF_BITS,
    parameter int ADRBITS = (NCOEFF > 1) ? $clog2(NCOEFF) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADRBITS-1:0] wr_adr,
    input  logic [CBITS-1:0]   wr_dat,
    input  logic [ADRBITS-1:0] rd_adr,
    output logic [CBITS-1:0]   rd_dat
);

    logic [CBITS-1:0] mem [NCOEFF];

    // Address decode by comparison against each entry index, so addresses
    // at or above NCOEFF simply match nothing and are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCOEFF; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NCOEFF; i++) begin
                if (wr_adr == ADRBITS'(i)) begin
                    mem[i] <= wr_dat;
                end
            end
        end
    end

    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < NCOEFF; i++) begin
            if (rd_adr == ADRBITS'(i)) begin
                rd_dat = mem[i];
            end
        end
    end

endmodule

// File: rtl/biquad_coeff_loader.sv
// Streams the shadow coefficients into a biquad B1/B2 cascade, highest index first, then commits.
// Latency: load at edge n -> first coeff_wr_o in cycle n+1, update in n+1+NCOEFF*(1+HOLD), done one later.
// Backpressure: none; loads while busy collapse into one pending flag that restarts right after done.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset (aborts any sequence)
//   cfg_adr_i/cfg_dat_i/cfg_wr_i    shadow register write port, accepted in every state
//   load_i                          start a sequence, or queue one if already busy
//   coeff_dat_o/coeff_wr_o          serial coefficient data and shift strobe (B1 enable)
//   coeff_update_o                  commit strobe (B2 enable)
//   busy_o, done_o                  sequence in progress or pending; one-cycle completion pulse
module biquad_coeff_loader
    import biquad_coeff_loader_pkg::*;
#(
    parameter int NCOEFF  = DEFAULT_NCOEFF,
    parameter int CBITS   = COEFF_BITS,
    parameter int HOLD    = 1,
    parameter int ADRBITS = (NCOEFF > 1) ? $clog2(NCOEFF) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADRBITS-1:0] cfg_adr_i,
    input  logic [CBITS-1:0]   cfg_dat_i,
    input  logic               cfg_wr_i,
    input  logic               load_i,
    output logic [CBITS-1:0]   coeff_dat_o,
    output logic               coeff_wr_o,
    output logic               coeff_update_o,
    output logic               busy_o,
    output logic               done_o
);

    // The hold counter only needs to represent 0..HOLD-1.
    localparam int                 HBITS  = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [ADRBITS-1:0] K_LAST = ADRBITS'(NCOEFF - 1);
    localparam logic [HBITS-1:0]   H_LAST = HBITS'(HOLD - 1);

    state_t             state, state_nxt;
    logic [ADRBITS-1:0] k, k_nxt;
    logic [HBITS-1:0]   cnt, cnt_nxt;
    logic               pend, pend_nxt;
    logic [CBITS-1:0]   dat, dat_nxt;
    logic               wr, wr_nxt;
    logic               upd, upd_nxt;
    logic               busy, busy_nxt;
    logic               done, done_nxt;

    logic [ADRBITS-1:0] rd_adr;
    logic [CBITS-1:0]   rd_dat;

    // Outputs are registered together with the state, so the shadow is read
    // for the index about to be entered: k-1 when leaving HOLD, otherwise the
    // top index for a fresh sequence. The read happens before this edge's
    // shadow write lands, so a same-cycle write delivers the old value.
    assign rd_adr = (state == ST_HOLD) ? (k - ADRBITS'(1)) : K_LAST;

    biquad_coeff_shadow #(
        .NCOEFF  (NCOEFF),
        .CBITS   (CBITS),
        .ADRBITS (ADRBITS)
    ) u_shadow (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (cfg_wr_i),
        .wr_adr (cfg_adr_i),
        .wr_dat (cfg_dat_i),
        .rd_adr (rd_adr),
        .rd_dat (rd_dat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            k     <= '0;
            cnt   <= '0;
            pend  <= 1'b0;
            dat   <= '0;
            wr    <= 1'b0;
            upd   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
            dat   <= dat_nxt;
            wr    <= wr_nxt;
            upd   <= upd_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        dat_nxt   = dat;
        wr_nxt    = 1'b0;
        upd_nxt   = 1'b0;
        done_nxt  = 1'b0;
        busy_nxt  = busy;

        unique case (state)
            ST_IDLE: begin
                dat_nxt  = '0;
                busy_nxt = 1'b0;
                if (load_i) begin
                    state_nxt = ST_WRITE;
                    k_nxt     = K_LAST;
                    dat_nxt   = rd_dat;
                    wr_nxt    = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end

            ST_WRITE: begin
                state_nxt = ST_HOLD;
                cnt_nxt   = H_LAST;
                if (load_i) pend_nxt = 1'b1;
            end

            ST_HOLD: begin
                if (load_i) pend_nxt = 1'b1;
                if (cnt == '0) begin
                    if (k != '0) begin
                        state_nxt = ST_WRITE;
                        k_nxt     = k - ADRBITS'(1);
                        dat_nxt   = rd_dat;
                        wr_nxt    = 1'b1;
                    end else begin
                        state_nxt = ST_UPDATE;
                        dat_nxt   = '0;
                        upd_nxt   = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - HBITS'(1);
                end
            end

            ST_UPDATE: begin
                if (load_i) pend_nxt = 1'b1;
                state_nxt = ST_DONE;
                done_nxt  = 1'b1;
            end

            ST_DONE: begin
                pend_nxt = 1'b0;
                // A load arriving in DONE counts as pending, so it restarts
                // immediately without passing through IDLE.
                if (pend || load_i) begin
                    state_nxt = ST_WRITE;
                    k_nxt     = K_LAST;
                    dat_nxt   = rd_dat;
                    wr_nxt    = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                pend_nxt  = 1'b0;
                dat_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign coeff_dat_o    = dat;
    assign coeff_wr_o     = wr;
    assign coeff_update_o = upd;
    assign busy_o         = busy;
    assign done_o         = done;

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// Self-checking bench for biquad_coeff_loader across three parameter sets.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_biquad_coeff_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance A: NCOEFF=2, HOLD=1
    logic        a_adr = 1'b0;
    logic [17:0] a_dat = '0;
    logic        a_wr = 1'b0, a_load = 1'b0;
    logic [17:0] a_cdat;
    logic        a_cwr, a_upd, a_busy, a_done;

    // Instance B: NCOEFF=4, HOLD=1
    logic [1:0]  b_adr = '0;
    logic [17:0] b_dat = '0;
    logic        b_wr = 1'b0, b_load = 1'b0;
    logic [17:0] b_cdat;
    logic        b_cwr, b_upd, b_busy, b_done;

    // Instance C: NCOEFF=3, HOLD=2
    logic [1:0]  c_adr = '0;
    logic [17:0] c_dat = '0;
    logic        c_wr = 1'b0, c_load = 1'b0;
    logic [17:0] c_cdat;
    logic        c_cwr, c_upd, c_busy, c_done;

    biquad_coeff_loader #(.NCOEFF(2), .CBITS(18), .HOLD(1)) u_a (
        .clk(clk), .rst(rst), .cfg_adr_i(a_adr), .cfg_dat_i(a_dat), .cfg_wr_i(a_wr),
        .load_i(a_load), .coeff_dat_o(a_cdat), .coeff_wr_o(a_cwr),
        .coeff_update_o(a_upd), .busy_o(a_busy), .done_o(a_done));

    biquad_coeff_loader #(.NCOEFF(4), .CBITS(18), .HOLD(1)) u_b (
        .clk(clk), .rst(rst), .cfg_adr_i(b_adr), .cfg_dat_i(b_dat), .cfg_wr_i(b_wr),
        .load_i(b_load), .coeff_dat_o(b_cdat), .coeff_wr_o(b_cwr),
        .coeff_update_o(b_upd), .busy_o(b_busy), .done_o(b_done));

    biquad_coeff_loader #(.NCOEFF(3), .CBITS(18), .HOLD(2)) u_c (
        .clk(clk), .rst(rst), .cfg_adr_i(c_adr), .cfg_dat_i(c_dat), .cfg_wr_i(c_wr),
        .load_i(c_load), .coeff_dat_o(c_cdat), .coeff_wr_o(c_cwr),
        .coeff_update_o(c_upd), .busy_o(c_busy), .done_o(c_done));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pack one cycle of outputs: {dat, wr, update, busy, done}.
    function automatic logic [63:0] pk(input logic [17:0] d, input logic w, input logic u,
                                       input logic b, input logic dn);
        return {42'd0, d, w, u, b, dn};
    endfunction

    // Expected outputs for NCOEFF=2, HOLD=1 at sequence cycle s (0 = first write).
    function automatic logic [63:0] exp_a(input int s, input logic [17:0] hi, input logic [17:0] lo);
        if (s < 0 || s > 5) return pk(18'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        return pk((s < 2) ? hi : ((s < 4) ? lo : 18'd0), (s == 0 || s == 2), (s == 4), 1'b1, (s == 5));
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // NCOEFF=4 sequence; optional mid-sequence writes. v[j] = j-th value on the wire.
    task automatic b_run(input logic [3:0][17:0] v, input bit wr_mid);
        b_load = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick;
            b_load = 1'b0;
            b_wr   = 1'b0;
            if (wr_mid) begin
                case (c)
                    2: begin b_wr = 1'b1; b_adr = 2'd2; b_dat = 18'h00077; end
                    3: begin b_wr = 1'b1; b_adr = 2'd3; b_dat = 18'h00005; end
                    4: begin b_wr = 1'b1; b_adr = 2'd0; b_dat = 18'h0000A; end
                    default: ;
                endcase
            end
            @(negedge clk);
            check("b_seq", pk(b_cdat, b_cwr, b_upd, b_busy, b_done),
                  pk((c <= 8) ? v[(c <= 8) ? (c - 1) / 2 : 0] : 18'd0,
                     (c <= 7) && (c % 2 == 1), (c == 9), (c <= 10), (c == 10)));
        end
    endtask

    // Reference model state for instance C (sequence-time view).
    localparam int NC = 3;
    localparam int PC = 3;          // 1 write + 2 hold cycles per coefficient
    localparam int NP = NC * PC;
    logic [17:0] m_sh [NC];
    logic [17:0] exp_commit [NC];
    logic [17:0] b1 [NC];
    logic [17:0] b2 [NC];
    logic [17:0] m_sent;
    bit          m_act, m_pend;
    int          m_t;
    int          commits;

    initial begin
        // Reset and idle
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a", pk(a_cdat, a_cwr, a_upd, a_busy, a_done), 64'd0);
        check("rst_b", pk(b_cdat, b_cwr, b_upd, b_busy, b_done), 64'd0);
        check("rst_c", pk(c_cdat, c_cwr, c_upd, c_busy, c_done), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick;
            @(negedge clk);
            check("idle_a", pk(a_cdat, a_cwr, a_upd, a_busy, a_done), 64'd0);
        end

        // Basic load, NCOEFF=2 HOLD=1
        tick; a_wr = 1'b1; a_adr = 1'b0; a_dat = 18'h00123;
        tick; a_adr = 1'b1; a_dat = 18'h3FFFF;
        tick; a_wr = 1'b0;
        a_load = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick;
            a_load = 1'b0;
            @(negedge clk);
            check("a_basic", pk(a_cdat, a_cwr, a_upd, a_busy, a_done),
                  exp_a(c - 1, 18'h3FFFF, 18'h00123));
        end

        // Queued load: loads in cycles 2 and 3 give exactly one more sequence
        tick;
        a_load = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick;
            a_load = (c == 2 || c == 3);
            @(negedge clk);
            check("a_queued", pk(a_cdat, a_cwr, a_upd, a_busy, a_done),
                  exp_a((c <= 6) ? c - 1 : ((c <= 12) ? c - 7 : -1), 18'h3FFFF, 18'h00123));
        end

        // Writes during a sequence, NCOEFF=4
        for (int i = 0; i < 4; i++) begin
            tick; b_wr = 1'b1; b_adr = 2'(i); b_dat = 18'h100 + 18'(i);
        end
        tick; b_wr = 1'b0;
        b_run({18'h0000A, 18'h00101, 18'h00102, 18'h00103}, 1'b1);
        tick;
        b_run({18'h0000A, 18'h00101, 18'h00077, 18'h00005}, 1'b0);

        // Reset during the second HOLD
        tick;
        a_load = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick;
            a_load = 1'b0;
            @(negedge clk);
            check("a_pre_rst", pk(a_cdat, a_cwr, a_upd, a_busy, a_done),
                  exp_a(c - 1, 18'h3FFFF, 18'h00123));
        end
        #2 rst = 1'b1;
        #1 check("a_rst_async", pk(a_cdat, a_cwr, a_upd, a_busy, a_done), 64'd0);
        tick; tick;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            @(negedge clk);
            check("a_after_rst", pk(a_cdat, a_cwr, a_upd, a_busy, a_done), 64'd0);
        end
        a_load = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick;
            a_load = 1'b0;
            @(negedge clk);
            check("a_zero_seq", pk(a_cdat, a_cwr, a_upd, a_busy, a_done), exp_a(c - 1, 18'd0, 18'd0));
        end

        // Random loads/writes on NCOEFF=3 HOLD=2 against the reference model
        for (int i = 0; i < NC; i++) begin
            m_sh[i] = '0; exp_commit[i] = '0; b1[i] = '0; b2[i] = '0;
        end
        m_act = 1'b0; m_pend = 1'b0; m_t = 0; m_sent = '0; commits = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick;
            // Advance the model with the inputs sampled at this edge.
            if (!m_act) begin
                if (c_load) begin m_act = 1'b1; m_t = 0; m_pend = 1'b0; end
            end else if (m_t == NP + 1) begin
                if (m_pend || c_load) begin m_t = 0; m_pend = 1'b0; end
                else m_act = 1'b0;
            end else begin
                m_t++;
                if (c_load) m_pend = 1'b1;
            end
            if (m_act && m_t < NP && (m_t % PC) == 0) begin
                m_sent = m_sh[NC - 1 - m_t / PC];
                exp_commit[NC - 1 - m_t / PC] = m_sent;
            end
            if (c_wr && c_adr < 2'd3) m_sh[c_adr] = c_dat;

            c_load = (cyc < 2900) && ($urandom_range(0, 11) == 0);
            c_wr   = ($urandom_range(0, 3) == 0);
            c_adr  = 2'($urandom_range(0, 3));
            c_dat  = 18'($urandom);

            @(negedge clk);
            check("c_out", pk(c_cdat, c_cwr, c_upd, c_busy, c_done),
                  pk((m_act && m_t < NP) ? m_sent : 18'd0,
                     m_act && m_t < NP && (m_t % PC) == 0,
                     m_act && m_t == NP, m_act, m_act && m_t == NP + 1));
            // DSP cascade: B1 shifts on each write strobe, B2 captures on update.
            if (c_cwr) begin
                for (int i = NC - 1; i > 0; i--) b1[i] = b1[i - 1];
                b1[0] = c_cdat;
            end
            if (c_upd) begin
                commits++;
                for (int i = 0; i < NC; i++) begin
                    b2[i] = b1[i];
                    check("c_b2", b2[i], exp_commit[i]);
                end
            end
        end
        check("c_commits_seen", 64'(commits > 0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
